// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue and its predecoder.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef PC_WIDHT
`define PC_WIDHT 32
`endif

package ifq_pkg;

  localparam int unsigned IFQ_INST_W = `INST_WIDTH;
  localparam int unsigned IFQ_PC_W   = `PC_WIDHT;
  localparam int unsigned OPC_W      = 7;

  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [IFQ_INST_W-1:0] inst;
    logic [IFQ_PC_W-1:0]   pc;
    logic                  is_branch;
    logic                  is_jal;
    logic                  is_jalr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_predecode.sv
// Combinational control-flow predecode of a RISC-V major opcode; shared with decode.
module ifq_predecode
  import ifq_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output logic             o_is_branch_c,
  output logic             o_is_jal_c,
  output logic             o_is_jalr_c
);

  always_comb begin
    o_is_branch_c = 1'b0;
    o_is_jal_c    = 1'b0;
    o_is_jalr_c   = 1'b0;
    unique case (i_opcode)
      OPC_BRANCH: o_is_branch_c = 1'b1;
      OPC_JAL:    o_is_jal_c    = 1'b1;
      OPC_JALR:   o_is_jalr_c   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ifq_buffer.sv
// Instruction fetch queue: circular buffer between prefetch and decode with
// store-time predecode, registered head/handshake outputs and one-cycle flush.
module ifq_buffer
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INST_W = IFQ_INST_W,
  parameter int unsigned PC_W   = IFQ_PC_W
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       pfu2ifq_valid_i,
  input  logic [INST_W-1:0]          pfu2ifq_inst_i,
  input  logic [PC_W-1:0]            pfu2ifq_pc_i,
  output logic                       ifq2pfu_ready_o,
  output logic                       ifq2dpu_valid_o,
  output logic [INST_W-1:0]          ifq2dpu_inst_o,
  output logic [PC_W-1:0]            ifq2dpu_pc_o,
  output logic                       ifq2dpu_is_branch_o,
  output logic                       ifq2dpu_is_jal_o,
  output logic                       ifq2dpu_is_jalr_o,
  input  logic                       dpu2ifq_ready_i,
  input  logic                       ctrl2ifq_flush_i,
  output logic [$clog2(DEPTH):0]     ifq_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ifq_entry_t       r_mem [DEPTH];
  ifq_entry_t       r_head;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;
  logic             r_valid;

  ifq_entry_t       w_new;
  ifq_entry_t       w_head_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_is_branch;
  logic             w_is_jal;
  logic             w_is_jalr;

  ifq_predecode u_predecode (
    .i_opcode      (pfu2ifq_inst_i[OPC_W-1:0]),
    .o_is_branch_c (w_is_branch),
    .o_is_jal_c    (w_is_jal),
    .o_is_jalr_c   (w_is_jalr)
  );

  // Next-state: handshakes, pointers, occupancy and the head entry for next cycle.
  always_comb begin
    w_new           = '0;
    w_new.inst      = pfu2ifq_inst_i;
    w_new.pc        = pfu2ifq_pc_i;
    w_new.is_branch = w_is_branch;
    w_new.is_jal    = w_is_jal;
    w_new.is_jalr   = w_is_jalr;

    w_push       = pfu2ifq_valid_i & r_ready & ~ctrl2ifq_flush_i;
    w_pop        = r_valid & dpu2ifq_ready_i & ~ctrl2ifq_flush_i;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_head_nxt   = '0;

    if (ctrl2ifq_flush_i) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end

    // The entry being written this cycle becomes head when it lands on the new read slot.
    if (w_count_nxt != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = w_new;
      else                                      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_head   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[PTR_W'(i)] <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_ready  <= (w_count_nxt != CNT_W'(DEPTH));
      r_valid  <= (w_count_nxt != '0);
      r_head   <= w_head_nxt;
      if (w_push) r_mem[r_wr_ptr] <= w_new;
    end
  end

  assign ifq2pfu_ready_o     = r_ready;
  assign ifq2dpu_valid_o     = r_valid;
  assign ifq2dpu_inst_o      = r_head.inst;
  assign ifq2dpu_pc_o        = r_head.pc;
  assign ifq2dpu_is_branch_o = r_head.is_branch;
  assign ifq2dpu_is_jal_o    = r_head.is_jal;
  assign ifq2dpu_is_jalr_o   = r_head.is_jalr;
  assign ifq_count_o         = r_count;

endmodule

// File: tb/tb_ifq_buffer.sv
// Directed, table-driven bench for ifq_buffer plus a streaming wrap sequence.
module tb_ifq_buffer;

  logic        clk_i;
  logic        rst_n_i;
  logic        pfu2ifq_valid_i;
  logic [31:0] pfu2ifq_inst_i;
  logic [31:0] pfu2ifq_pc_i;
  logic        ifq2pfu_ready_o;
  logic        ifq2dpu_valid_o;
  logic [31:0] ifq2dpu_inst_o;
  logic [31:0] ifq2dpu_pc_o;
  logic        ifq2dpu_is_branch_o;
  logic        ifq2dpu_is_jal_o;
  logic        ifq2dpu_is_jalr_o;
  logic        dpu2ifq_ready_i;
  logic        ctrl2ifq_flush_i;
  logic [2:0]  ifq_count_o;

  ifq_buffer #(.DEPTH(4)) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .pfu2ifq_valid_i     (pfu2ifq_valid_i),
    .pfu2ifq_inst_i      (pfu2ifq_inst_i),
    .pfu2ifq_pc_i        (pfu2ifq_pc_i),
    .ifq2pfu_ready_o     (ifq2pfu_ready_o),
    .ifq2dpu_valid_o     (ifq2dpu_valid_o),
    .ifq2dpu_inst_o      (ifq2dpu_inst_o),
    .ifq2dpu_pc_o        (ifq2dpu_pc_o),
    .ifq2dpu_is_branch_o (ifq2dpu_is_branch_o),
    .ifq2dpu_is_jal_o    (ifq2dpu_is_jal_o),
    .ifq2dpu_is_jalr_o   (ifq2dpu_is_jalr_o),
    .dpu2ifq_ready_i     (dpu2ifq_ready_i),
    .ctrl2ifq_flush_i    (ctrl2ifq_flush_i),
    .ifq_count_o         (ifq_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        dpu_rdy;
    logic        flush;
    logic [2:0]  e_cnt;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [2:0]  e_flags;   // {branch, jal, jalr}
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst_n, input logic valid, input logic [31:0] inst,
                     input logic [31:0] pc, input logic dpu_rdy, input logic flush,
                     input logic [2:0] e_cnt, input logic e_valid, input logic e_ready,
                     input logic [31:0] e_pc, input logic [31:0] e_inst, input logic [2:0] e_flags);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.inst = inst; v.pc = pc;
    v.dpu_rdy = dpu_rdy; v.flush = flush; v.e_cnt = e_cnt; v.e_valid = e_valid;
    v.e_ready = e_ready; v.e_pc = e_pc; v.e_inst = e_inst; v.e_flags = e_flags;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst_n, input logic valid, input logic [31:0] inst,
                       input logic [31:0] pc, input logic dpu_rdy, input logic flush);
    rst_n_i = rst_n; pfu2ifq_valid_i = valid; pfu2ifq_inst_i = inst;
    pfu2ifq_pc_i = pc; dpu2ifq_ready_i = dpu_rdy; ctrl2ifq_flush_i = flush;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset state
    add(0,0,32'h0,32'h0,0,0,             3'd0,0,1,32'h0,32'h0,3'b000);
    // Push 0x0,0x4,0x8 with decode stalled
    add(1,1,32'h00000013,32'h0,0,0,       3'd1,1,1,32'h0,32'h00000013,3'b000);
    add(1,1,32'h00100093,32'h4,0,0,       3'd2,1,1,32'h0,32'h00000013,3'b000);
    add(1,1,32'h00200113,32'h8,0,0,       3'd3,1,1,32'h0,32'h00000013,3'b000);
    // Fill, then hold a 5th entry against full
    add(1,1,32'h00300193,32'hC,0,0,       3'd4,1,0,32'h0,32'h00000013,3'b000);
    add(1,1,32'h00400213,32'h10,0,0,      3'd4,1,0,32'h0,32'h00000013,3'b000);
    // Drain in order; the held 5th entry must not appear
    add(1,0,32'h0,32'h0,1,0,              3'd3,1,1,32'h4,32'h00100093,3'b000);
    add(1,0,32'h0,32'h0,1,0,              3'd2,1,1,32'h8,32'h00200113,3'b000);
    add(1,0,32'h0,32'h0,1,0,              3'd1,1,1,32'hC,32'h00300193,3'b000);
    add(1,0,32'h0,32'h0,1,0,              3'd0,0,1,32'h0,32'h0,3'b000);
    // count=3, then push coincident with flush
    add(1,1,32'h00000013,32'h20,0,0,      3'd1,1,1,32'h20,32'h00000013,3'b000);
    add(1,1,32'h00000013,32'h24,0,0,      3'd2,1,1,32'h20,32'h00000013,3'b000);
    add(1,1,32'h00000013,32'h28,0,0,      3'd3,1,1,32'h20,32'h00000013,3'b000);
    add(1,1,32'h00000013,32'h2C,1,1,      3'd0,0,1,32'h0,32'h0,3'b000);
    add(1,1,32'h00000033,32'h100,0,0,     3'd1,1,1,32'h100,32'h00000033,3'b000);
    add(1,0,32'h0,32'h0,1,0,              3'd0,0,1,32'h0,32'h0,3'b000);
    // Predecode flags
    add(1,1,32'h00000063,32'h200,0,0,     3'd1,1,1,32'h200,32'h00000063,3'b100);
    add(1,1,32'h0000006F,32'h204,0,0,     3'd2,1,1,32'h200,32'h00000063,3'b100);
    add(1,1,32'h00000067,32'h208,0,0,     3'd3,1,1,32'h200,32'h00000063,3'b100);
    add(1,1,32'h00000013,32'h20C,0,0,     3'd4,1,0,32'h200,32'h00000063,3'b100);
    add(1,0,32'h0,32'h0,1,0,              3'd3,1,1,32'h204,32'h0000006F,3'b010);
    add(1,0,32'h0,32'h0,1,0,              3'd2,1,1,32'h208,32'h00000067,3'b001);
    add(1,0,32'h0,32'h0,1,0,              3'd1,1,1,32'h20C,32'h00000013,3'b000);
    add(1,0,32'h0,32'h0,1,0,              3'd0,0,1,32'h0,32'h0,3'b000);
    // Fill, then reset while full
    add(1,1,32'h0000006F,32'h300,0,0,     3'd1,1,1,32'h300,32'h0000006F,3'b010);
    add(1,1,32'h0000006F,32'h304,0,0,     3'd2,1,1,32'h300,32'h0000006F,3'b010);
    add(1,1,32'h0000006F,32'h308,0,0,     3'd3,1,1,32'h300,32'h0000006F,3'b010);
    add(1,1,32'h0000006F,32'h30C,0,0,     3'd4,1,0,32'h300,32'h0000006F,3'b010);
    add(0,1,32'h0000006F,32'h310,1,0,     3'd0,0,1,32'h0,32'h0,3'b000);
    add(1,0,32'h0,32'h0,0,0,              3'd0,0,1,32'h0,32'h0,3'b000);
    // Push into empty with decode ready: visible one cycle later, then push+pop at count=1
    add(1,1,32'h00000067,32'h400,1,0,     3'd1,1,1,32'h400,32'h00000067,3'b001);
    add(1,1,32'h00000063,32'h404,1,0,     3'd1,1,1,32'h404,32'h00000063,3'b100);
    add(1,0,32'h0,32'h0,1,0,              3'd0,0,1,32'h0,32'h0,3'b000);
    // Flush on an empty queue is harmless
    add(1,0,32'h0,32'h0,1,1,              3'd0,0,1,32'h0,32'h0,3'b000);

    step();
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].valid, vecs[i].inst, vecs[i].pc, vecs[i].dpu_rdy, vecs[i].flush);
      step();
      chk($sformatf("v%0d count", i), 32'(ifq_count_o), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d valid", i), 32'(ifq2dpu_valid_o), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d ready", i), 32'(ifq2pfu_ready_o), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d pc", i), ifq2dpu_pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d inst", i), ifq2dpu_inst_o, vecs[i].e_inst);
      chk($sformatf("v%0d flags", i),
          32'({ifq2dpu_is_branch_o, ifq2dpu_is_jal_o, ifq2dpu_is_jalr_o}), 32'(vecs[i].e_flags));
    end

    // Streaming at count=2 for 20 cycles; pointers wrap several times
    drive(1'b1, 1'b1, 32'h13, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h13, 32'h4, 1'b0, 1'b0);
    step();
    chk("stream prefill count", 32'(ifq_count_o), 32'd2);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 32'h13, 32'(8 + 4 * k), 1'b1, 1'b0);
      chk($sformatf("stream pop%0d pc", k), ifq2dpu_pc_o, 32'(4 * k));
      chk($sformatf("stream pop%0d ready", k), 32'(ifq2pfu_ready_o), 32'd1);
      step();
      chk($sformatf("stream cyc%0d count", k), 32'(ifq_count_o), 32'd2);
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("stream tail0 pc", ifq2dpu_pc_o, 32'h50);
    step();
    chk("stream tail1 pc", ifq2dpu_pc_o, 32'h54);
    chk("stream tail1 count", 32'(ifq_count_o), 32'd1);
    step();
    chk("stream drained count", 32'(ifq_count_o), 32'd0);
    chk("stream drained valid", 32'(ifq2dpu_valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
